seg7_scan_driver: RTL and testbench

- Consumes the 16-bit packed-BCD time word produced by the stopwatch/clock service blocks and drives a 4-digit multiplexed 7-segment display.
- Digit 3 = value[15:12] (leftmost), digit 0 = value[3:0] (rightmost).
- Provides:
  - time-division digit scanning;
  - BCD-to-segment decode;
  - frame-synchronous value update;
  - leading-zero blanking;
  - per-digit decimal points;
  - whole-display blink.
- Sits between the service FSMs and the board anode/cathode pins.

---
 rtl/seg7_scan_driver.sv | 196 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver for packed-BCD time words.
// Frame-synchronous value update, leading-zero blanking, per-digit decimal points and blink.
module seg7_scan_driver #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_HZ   = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  input  logic        blink_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int SCAN_DIV   = CLOCK_FREQ / SCAN_HZ;
  localparam int BLINK_HALF = CLOCK_FREQ / (2 * BLINK_HZ);
  localparam int SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  // XOR masks that turn active-high patterns into pin levels (and give the dark level).
  localparam logic [3:0] AN_POL  = (ACTIVE_LOW != 0) ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_POL  = (ACTIVE_LOW != 0) ? 1'b1  : 1'b0;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         digit_q, digit_d;
  logic               frame_q, frame_d;
  logic [15:0]        shadow_q, shadow_d;
  logic [15:0]        pending_q, pending_d;
  logic               pend_valid_q, pend_valid_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic [3:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;

  logic               tick_s;
  logic               boundary_s;
  logic               blink_wrap_s;
  logic [3:0]         lz_blank_s;
  logic [3:0]         nib_s;
  logic               lit_s;

  assign tick_s       = (scan_cnt_q == SCAN_LAST);
  assign boundary_s   = tick_s && (digit_q == 2'd3);
  assign blink_wrap_s = (blink_cnt_q == BLINK_LAST);

  // Scan timebase: per-digit dwell counter, digit index and frame pulse.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    digit_d    = digit_q;
    frame_d    = boundary_s;
    if (tick_s) begin
      scan_cnt_d = {SCAN_W{1'b0}};
      digit_d    = digit_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    end
  end

  // Value capture: loads park in pending; shadow only changes at a frame boundary.
  always_comb begin
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    shadow_d     = shadow_q;
    if (load) begin
      pending_d = value;
    end else begin
      pending_d = pending_q;
    end
    if (boundary_s) begin
      pend_valid_d = 1'b0;
      if (load) begin
        shadow_d = value;
      end else if (pend_valid_q) begin
        shadow_d = pending_q;
      end else begin
        shadow_d = shadow_q;
      end
    end else if (load) begin
      pend_valid_d = 1'b1;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // Blink phase generator; parked in the ON phase while blink is disabled.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (blink_en) begin
      if (blink_wrap_s) begin
        blink_cnt_d = {BLINK_W{1'b0}};
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end else begin
      blink_cnt_d = {BLINK_W{1'b0}};
      blink_on_d  = 1'b1;
    end
  end

  // Leading-zero blanking chains from the left: a digit blanks only if every digit left of it does.
  always_comb begin
    lz_blank_s    = 4'b0000;
    lz_blank_s[3] = blank_lz && (shadow_q[15:12] == 4'h0) && !dp_mask[3];
    lz_blank_s[2] = lz_blank_s[3] && (shadow_q[11:8] == 4'h0) && !dp_mask[2];
    lz_blank_s[1] = lz_blank_s[2] && (shadow_q[7:4] == 4'h0) && !dp_mask[1];
    lz_blank_s[0] = 1'b0;
  end

  // Current-digit nibble select and pin-level output computation.
  always_comb begin
    case (digit_q)
      2'd0:    nib_s = shadow_q[3:0];
      2'd1:    nib_s = shadow_q[7:4];
      2'd2:    nib_s = shadow_q[11:8];
      2'd3:    nib_s = shadow_q[15:12];
      default: nib_s = shadow_q[3:0];
    endcase
    lit_s = !lz_blank_s[digit_q] && blink_on_q;
    if (lit_s) begin
      an_d  = (4'b0001 << digit_q) ^ AN_POL;
      seg_d = bcd_to_seg(nib_s) ^ SEG_POL;
      dp_d  = dp_mask[digit_q] ^ DP_POL;
    end else begin
      an_d  = AN_POL;
      seg_d = SEG_POL;
      dp_d  = DP_POL;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_q   <= {SCAN_W{1'b0}};
      digit_q      <= 2'd0;
      frame_q      <= 1'b0;
      shadow_q     <= 16'h0000;
      pending_q    <= 16'h0000;
      pend_valid_q <= 1'b0;
      blink_cnt_q  <= {BLINK_W{1'b0}};
      blink_on_q   <= 1'b1;
      an_q         <= AN_POL;
      seg_q        <= SEG_POL;
      dp_q         <= DP_POL;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      digit_q      <= digit_d;
      frame_q      <= frame_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (SCAN_DIV=10, BLINK_HALF=10, active-low pins).
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic        blink_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int checks;
  int failures;

  seg7_scan_driver #(
    .CLOCK_FREQ(1000),
    .SCAN_HZ   (100),
    .BLINK_HZ  (50),
    .ACTIVE_LOW(1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .load    (load),
    .blank_lz(blank_lz),
    .dp_mask (dp_mask),
    .blink_en(blink_en),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_load(input int k, input int a0, input logic [15:0] v0,
                            input int a1, input logic [15:0] v1);
    if (k == a0) begin
      value = v0;
      load  = 1'b1;
    end else if (k == a1) begin
      value = v1;
      load  = 1'b1;
    end else begin
      load  = 1'b0;
    end
  endtask

  // Called at the negedge of a frame-pulse cycle; checks the next 40 cycles (one full frame).
  // segs packs the active-high-to-pin seg levels {d3,d2,d1,d0}; lit marks digits whose anode is on;
  // seg_chk marks digits whose seg/dp are checked; dpl marks digits whose dp is lit.
  // Loads are scheduled at sample index a0/a1 (0 = before first sample, 39 = captured on the boundary).
  task automatic expect_frame(input string tag, input logic [27:0] segs, input logic [3:0] lit,
                              input logic [3:0] seg_chk, input logic [3:0] dpl,
                              input int a0, input logic [15:0] v0,
                              input int a1, input logic [15:0] v1);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         d;
    drive_load(0, a0, v0, a1, v1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      d       = (k - 1) / 10;
      exp_an  = lit[d] ? ~(4'b0001 << d) : 4'hF;
      exp_seg = lit[d] ? segs[d*7 +: 7] : 7'h7F;
      exp_dp  = lit[d] ? ~dpl[d] : 1'b1;
      check({tag, " an"}, {12'h000, an}, {12'h000, exp_an});
      if (seg_chk[d]) begin
        check({tag, " seg"}, {9'h000, seg}, {9'h000, exp_seg});
        check({tag, " dp"}, {15'h0000, dp}, {15'h0000, exp_dp});
      end
      check({tag, " frame"}, {15'h0000, frame}, {15'h0000, (k == 40)});
      drive_load(k, a0, v0, a1, v1);
    end
  endtask

  initial begin
    logic found;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    value    = 16'h0000;
    load     = 1'b0;
    blank_lz = 1'b0;
    dp_mask  = 4'h0;
    blink_en = 1'b0;
    found    = 1'b0;

    repeat (3) @(negedge clk);
    check("rst an", {12'h000, an}, 16'h000F);
    check("rst seg", {9'h000, seg}, 16'h007F);
    check("rst dp", {15'h0000, dp}, 16'h0001);
    check("rst frame", {15'h0000, frame}, 16'h0000);

    reset = 1'b0;
    @(negedge clk);
    check("release an", {12'h000, an}, 16'h000E);
    check("release seg", {9'h000, seg}, 16'h0040);

    value = 16'h1234;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("preframe an", {12'h000, an}, 16'h000E);
    check("preframe seg", {9'h000, seg}, 16'h0040);

    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("preframe zero", {9'h000, seg}, 16'h0040);
      if (frame) begin
        found = 1'b1;
        break;
      end
    end
    check("first frame seen", {15'h0000, found}, 16'h0001);

    // 1234 shown, 0047 loaded for the next frame.
    expect_frame("f1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF, 4'h0, 0, 16'h0047, -1, 16'h0000);
    blank_lz = 1'b1;
    expect_frame("lz0047", {7'h7F, 7'h7F, 7'h19, 7'h78}, 4'h3, 4'hF, 4'h0, 0, 16'h0000, -1, 16'h0000);
    expect_frame("lz0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'h1, 4'hF, 4'h0, 0, 16'h0512, -1, 16'h0000);
    dp_mask = 4'b0100;
    expect_frame("dp0512", {7'h7F, 7'h12, 7'h79, 7'h24}, 4'h7, 4'hF, 4'h4, 0, 16'h0012, -1, 16'h0000);
    expect_frame("dp0012", {7'h7F, 7'h40, 7'h79, 7'h24}, 4'h7, 4'hF, 4'h4, 0, 16'hA9F0, -1, 16'h0000);
    blank_lz = 1'b0;
    dp_mask  = 4'h0;
    // Mid-frame load must not disturb the frame in progress.
    expect_frame("badnib", {7'h3F, 7'h10, 7'h3F, 7'h40}, 4'hF, 4'hF, 4'h0, 15, 16'h1111, -1, 16'h0000);
    // Load captured on the boundary edge itself.
    expect_frame("f1111", {7'h79, 7'h79, 7'h79, 7'h79}, 4'hF, 4'hF, 4'h0, 39, 16'h2222, -1, 16'h0000);
    expect_frame("f2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 4'hF, 4'h0, 5, 16'h3333, 25, 16'h4444);
    expect_frame("f4444", {7'h19, 7'h19, 7'h19, 7'h19}, 4'hF, 4'hF, 4'h0, -1, 16'h0000, -1, 16'h0000);

    // Blink phases of 10 cycles line up with digit slots: ON, OFF, ON, OFF.
    blink_en = 1'b1;
    expect_frame("blink", {7'h19, 7'h19, 7'h19, 7'h19}, 4'h5, 4'h5, 4'h0, -1, 16'h0000, -1, 16'h0000);

    repeat (3) @(negedge clk);
    check("prereset an", {12'h000, an}, 16'h000E);
    reset = 1'b1;
    #1;
    check("async rst an", {12'h000, an}, 16'h000F);
    check("async rst seg", {9'h000, seg}, 16'h007F);
    check("async rst dp", {15'h0000, dp}, 16'h0001);
    blink_en = 1'b0;
    repeat (2) @(negedge clk);
    check("held rst an", {12'h000, an}, 16'h000F);
    reset = 1'b0;
    @(negedge clk);
    check("rerelease an", {12'h000, an}, 16'h000E);
    check("rerelease seg", {9'h000, seg}, 16'h0040);
    check("rerelease dp", {15'h0000, dp}, 16'h0001);
    check("rerelease frame", {15'h0000, frame}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
